// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter joining N 4-phase req/ack emitters onto one consumer channel.
// The winner index is registered into `selected` and held for the whole transaction.
module rr_handshake_arbiter #(
  parameter int N     = 5,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     reqs_in,
  output logic [N-1:0]     acks_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [SEL_W-1:0] selected
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACKED   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_r, state_next_s;
  logic [SEL_W-1:0]   ptr_r, ptr_next_s;
  logic [SEL_W-1:0]   sel_r, sel_next_s;
  logic               req_r, req_next_s;
  logic [N-1:0]       acks_r, acks_next_s;
  logic [SEL_W-1:0]   winner_s;
  logic               any_req_s;
  logic               sel_req_s;
  logic [N-1:0]       sel_onehot_s;
  logic [SEL_W-1:0]   ptr_after_s;

  // Rotate the request vector so the pointer lands on bit 0, take the lowest set bit,
  // then rotate the offset back into an absolute index.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0] reqs,
                                               input logic [SEL_W-1:0] ptr);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             idx;
    dbl = {reqs, reqs} >> ptr;
    rot = dbl[N-1:0];
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      off = rot[k] ? k : off;
    end
    idx = int'(ptr) + off;
    idx = (idx >= N) ? (idx - N) : idx;
    return idx[SEL_W-1:0];
  endfunction

  assign winner_s     = rr_pick(reqs_in, ptr_r);
  assign any_req_s    = |reqs_in;
  assign sel_req_s    = reqs_in[sel_r];
  assign sel_onehot_s = {{(N-1){1'b0}}, 1'b1} << sel_r;
  assign ptr_after_s  = (sel_r == SEL_W'(N - 1)) ? {SEL_W{1'b0}} : (sel_r + SEL_W'(1));

  assign acks_in  = acks_r;
  assign req_out  = req_r;
  assign selected = sel_r;

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= {SEL_W{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      req_r   <= 1'b0;
      acks_r  <= {N{1'b0}};
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      sel_r   <= sel_next_s;
      req_r   <= req_next_s;
      acks_r  <= acks_next_s;
    end
  end

  // Next-state logic for the handshake sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_next_s = GRANT;
        else           state_next_s = IDLE;
      end
      GRANT: begin
        if (ack_out) state_next_s = ACKED;
        else         state_next_s = GRANT;
      end
      ACKED: begin
        if (!sel_req_s) state_next_s = RELEASE;
        else            state_next_s = ACKED;
      end
      RELEASE: begin
        if (!ack_out) state_next_s = IDLE;
        else          state_next_s = RELEASE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the priority pointer.
  always_comb begin
    sel_next_s  = sel_r;
    req_next_s  = req_r;
    acks_next_s = acks_r;
    ptr_next_s  = ptr_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          sel_next_s = winner_s;
          req_next_s = 1'b1;
        end else begin
          req_next_s = 1'b0;
        end
      end
      GRANT: begin
        if (ack_out) acks_next_s = sel_onehot_s;
        else         acks_next_s = acks_r;
      end
      ACKED: begin
        if (!sel_req_s) req_next_s = 1'b0;
        else            req_next_s = req_r;
      end
      RELEASE: begin
        if (!ack_out) begin
          acks_next_s = {N{1'b0}};
          ptr_next_s  = ptr_after_s;
        end else begin
          acks_next_s = acks_r;
        end
      end
      default: begin
        req_next_s  = 1'b0;
        acks_next_s = {N{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Self-checking bench for rr_handshake_arbiter: directed sequences, a vector table
// and randomized emitters/consumer checked by a transaction-level reference model.
module tb_rr_handshake_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] reqs;
  logic [4:0] acks;
  logic       req_out;
  logic       ack_out;
  logic [2:0] selected;

  int checks = 0;
  int errors = 0;

  rr_handshake_arbiter #(.N(5), .SEL_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqs_in  (reqs),
    .acks_in  (acks),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .selected (selected)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Values seen by the DUT at the upcoming edge and outputs before it.
  logic [4:0] samp_reqs;
  logic       samp_ack;
  logic       samp_rst;
  logic       prev_req;
  logic [4:0] prev_acks;
  logic [2:0] prev_sel;
  int         mptr = 0;
  int         wait_cnt [5];
  int         grants = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Spec rule: first requester found scanning from the pointer upward with wrap.
  function automatic int model_winner(input logic [4:0] r, input int p);
    for (int k = 0; k < 5; k++) begin
      if (r[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  task automatic monitor();
    logic [4:0] oh;
    int w;
    if (samp_rst) begin
      mptr = 0;
      for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
    end else begin
      check("acks_onehot0", 32'($onehot0(acks)), 32'd1);
      if (prev_req || prev_acks != 5'd0) check("sel_stable", 32'(selected), 32'(prev_sel));
      if (!prev_req && req_out) begin
        w = model_winner(samp_reqs, mptr);
        check("grant_winner", 32'(selected), w);
        grants++;
        for (int i = 0; i < 5; i++) begin
          if (i == w) wait_cnt[i] = 0;
          else if (samp_reqs[i]) begin
            wait_cnt[i]++;
            check("no_starvation", 32'(wait_cnt[i] <= 4), 32'd1);
          end else wait_cnt[i] = 0;
        end
      end
      if (prev_acks == 5'd0 && acks != 5'd0) begin
        oh = 5'b00001 << selected;
        check("ack_matches_sel", 32'(acks), 32'(oh));
        check("ack_follows_ack_out", 32'(samp_ack), 32'd1);
      end
      if (prev_req && !req_out) check("req_drop_after_req_low", 32'(samp_reqs[selected]), 32'd0);
      if (prev_acks != 5'd0 && acks == 5'd0) begin
        check("release_after_ack_low", 32'(samp_ack), 32'd0);
        mptr = (int'(prev_sel) + 1) % 5;
      end
    end
  endtask

  task automatic tick();
    samp_reqs = reqs;
    samp_ack  = ack_out;
    samp_rst  = reset;
    prev_req  = req_out;
    prev_acks = acks;
    prev_sel  = selected;
    @(posedge clk);
    #1;
    monitor();
  endtask

  // what: 0 = req_out, 1 = any acks_in bit.
  task automatic wait_until(input int what, input logic want);
    int   n;
    logic cur;
    n   = 0;
    cur = (what == 0) ? req_out : (|acks);
    while (cur !== want && n < 20) begin
      tick();
      n++;
      cur = (what == 0) ? req_out : (|acks);
    end
    if (cur !== want) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout signal=%0d actual=%0b required=%0b", what, cur, want);
    end
  endtask

  // Full transaction: only the winner drops its request; others keep theirs.
  task automatic do_txn(input logic [4:0] r, output logic [2:0] sel);
    reqs = r;
    wait_until(0, 1'b1);
    sel = selected;
    ack_out = 1'b1;
    wait_until(1, 1'b1);
    reqs[sel] = 1'b0;
    wait_until(0, 1'b0);
    ack_out = 1'b0;
    wait_until(1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqs = 5'd0;
    ack_out = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] prime;
    logic [4:0] reqs;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t       vecs [9];
  logic [2:0] s;
  logic [4:0] oh;
  logic [31:0] data [5];
  logic [31:0] cap;
  int          g0;

  initial begin
    // Priming grant to `prime` leaves the pointer at prime+1.
    vecs[0] = '{3'd4, 5'b00100, 3'd2};
    vecs[1] = '{3'd0, 5'b00001, 3'd0};
    vecs[2] = '{3'd1, 5'b10011, 3'd4};
    vecs[3] = '{3'd3, 5'b10001, 3'd4};
    vecs[4] = '{3'd4, 5'b11110, 3'd1};
    vecs[5] = '{3'd2, 5'b00111, 3'd0};
    vecs[6] = '{3'd2, 5'b01111, 3'd3};
    vecs[7] = '{3'd0, 5'b11111, 3'd1};
    vecs[8] = '{3'd3, 5'b01111, 3'd0};

    do_reset();
    check("reset_req_out", 32'(req_out), 32'd0);
    check("reset_acks", 32'(acks), 32'd0);
    check("reset_sel", 32'(selected), 32'd0);

    // Single request with a consumer that acks two cycles after req_out.
    reqs = 5'b00100;
    tick();
    check("single_req_out", 32'(req_out), 32'd1);
    check("single_sel", 32'(selected), 32'd2);
    tick();
    tick();
    check("single_no_early_ack", 32'(acks), 32'd0);
    ack_out = 1'b1;
    tick();
    check("single_acks", 32'(acks), 32'b00100);
    reqs = 5'd0;
    tick();
    check("single_req_fall", 32'(req_out), 32'd0);
    check("single_acks_held", 32'(acks), 32'b00100);
    ack_out = 1'b0;
    tick();
    check("single_acks_clear", 32'(acks), 32'd0);
    check("single_sel_held", 32'(selected), 32'd2);

    // Idle hold after a grant to 3.
    do_txn(5'b01000, s);
    check("idle_grant3", 32'(s), 32'd3);
    reqs = 5'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_hold", {23'd0, req_out, acks, selected}, {23'd0, 1'b0, 5'd0, 3'd3});
    end

    // Round-robin with every requester continuously active.
    do_reset();
    for (int t = 0; t < 10; t++) begin
      do_txn(5'b11111, s);
      check("rr_order", 32'(s), 32'(t % 5));
    end
    reqs = 5'd0;
    tick();

    // Wrap: pointer reaches 4, then 4 wins, then 0.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      oh = 5'b00001 << t;
      do_txn(oh, s);
      check("wrap_setup", 32'(s), 32'(t));
    end
    do_txn(5'b10001, s);
    check("wrap_grant4", 32'(s), 32'd4);
    do_txn(5'b10001, s);
    check("wrap_grant0", 32'(s), 32'd0);
    reqs = 5'd0;
    tick();

    // Reset while ACKED; pointer is 1 beforehand so a stale pointer would pick 4.
    reqs = 5'b01000;
    wait_until(0, 1'b1);
    check("midrst_sel", 32'(selected), 32'd3);
    ack_out = 1'b1;
    wait_until(1, 1'b1);
    reset = 1'b1;
    tick();
    check("midrst_req_out", 32'(req_out), 32'd0);
    check("midrst_acks", 32'(acks), 32'd0);
    check("midrst_selected", 32'(selected), 32'd0);
    reset = 1'b0;
    ack_out = 1'b0;
    reqs = 5'd0;
    tick();
    do_txn(5'b10001, s);
    check("midrst_fresh_grant", 32'(s), 32'd0);
    reqs = 5'd0;
    tick();

    // Vector table: prime the pointer, then check the winner.
    for (int i = 0; i < 9; i++) begin
      oh = 5'b00001 << vecs[i].prime;
      do_txn(oh, s);
      check("vec_prime", 32'(s), 32'(vecs[i].prime));
      reqs = 5'd0;
      tick();
      do_txn(vecs[i].reqs, s);
      check("vec_winner", 32'(s), 32'(vecs[i].exp_sel));
      reqs = 5'd0;
      tick();
    end

    // Randomized emitters and consumer.
    do_reset();
    g0 = grants;
    cap = 32'd0;
    for (int i = 0; i < 5; i++) data[i] = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (req_out && !ack_out && acks == 5'd0 && $urandom_range(0, 2) == 0) begin
        ack_out = 1'b1;
        cap = data[selected];
      end else if (!req_out && ack_out && $urandom_range(0, 1) == 0) begin
        ack_out = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        if (!reqs[i] && !acks[i] && $urandom_range(0, 3) == 0) begin
          data[i] = $urandom;
          reqs[i] = 1'b1;
        end else if (reqs[i] && acks[i] && $urandom_range(0, 1) == 0) begin
          check("consumer_data", cap, data[i]);
          reqs[i] = 1'b0;
        end
      end
      tick();
    end
    check("random_progress", 32'((grants - g0) >= 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
